// File: rtl/seq_divider_if.sv
// Request/result bundle between the EX stage and the sequential divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multicycle restoring shift-and-subtract divider, one quotient bit per clock,
// serving DIV/DIVU/REM/REMU with sign fix-up applied after the magnitude loop.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r, dz;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             done_r, dz_r;
  logic             accept;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   trial;

  // Operand sign/magnitude and the trial subtraction for the current bit.
  always_comb begin
    sgn_a   = bus.is_signed & bus.dividend[WIDTH-1];
    sgn_b   = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_abs = sgn_a ? -bus.dividend : bus.dividend;
    dvs_abs = sgn_b ? -bus.divisor  : bus.divisor;
    trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    // The done cycle follows FIX with state already IDLE; gating on done_r
    // keeps that cycle part of the busy window so a start there is ignored.
    accept  = (state == IDLE) && !done_r && bus.start;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (bus.divisor == '0) ? FIX : CALC;
      CALC: if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            quotient_r  <= '0;
            remainder_r <= '0;
            dz_r        <= 1'b0;
            count       <= '0;
            dvs         <= dvs_abs;
            if (bus.divisor == '0) begin
              // Divide-by-zero result is staged directly; no sign fix-up.
              dz    <= 1'b1;
              quo   <= '1;
              rem   <= bus.dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              dz    <= 1'b0;
              quo   <= dvd_abs;
              rem   <= '0;
              neg_q <= sgn_a ^ sgn_b;
              neg_r <= sgn_a;
            end
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient_r  <= neg_q ? -quo : quo;
          remainder_r <= neg_r ? -rem : rem;
          dz_r        <= dz;
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.busy        = (state != IDLE) || done_r;
    bus.done        = done_r;
    bus.quotient    = quotient_r;
    bus.remainder   = remainder_r;
    bus.div_by_zero = dz_r;
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, random operands
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: magnitudes divided with 64-bit signed arithmetic (truncating
  // toward zero), divide-by-zero handled as a special result.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, mq, mr;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      mq = sa / sb;
      mr = sa % sb;
      q  = mq[31:0];
      r  = mr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Issue one request from idle, wait (bounded) for done, then one more edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output logic busy_ok, output logic drop_ok);
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    step();
    drop_ok = !bus.done && !bus.busy;
  endtask

  task automatic check_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
    logic [31:0] q, r;
    logic        dz, busy_ok, drop_ok;
    int          lat;
    run_op(s, a, b, q, r, dz, lat, busy_ok, drop_ok);
    check({tag, ".q"},    q,  eq);
    check({tag, ".r"},    r,  er);
    check({tag, ".dz"},   dz, edz);
    check({tag, ".lat"},  lat, (b == 32'd0) ? 1 : 33);
    check({tag, ".busy"}, busy_ok, 1'b1);
    check({tag, ".drop"}, drop_ok, 1'b1);
  endtask

  initial begin
    logic [31:0] q, r, ra, rb;
    logic        dz, rs;
    int          lat, seen_done, seen_busy;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'h2,          32'h7FFF_FFFC,  32'h1,          1'b0};
    vecs[3]  = '{1'b1, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[4]  = '{1'b0, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h1,          32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h1,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'h2,          32'hFFFF_FFFE,  1'b0};
    vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[10] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'h1,          32'h8000_0000,  32'h0,          1'b0};
    vecs[12] = '{1'b1, 32'hFFFF_FFF9,  32'h0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    vecs[13] = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("reset.busy", bus.busy, 1'b0);
    check("reset.done", bus.done, 1'b0);
    check("reset.q",    bus.quotient, 32'd0);
    check("reset.r",    bus.remainder, 32'd0);
    check("reset.dz",   bus.div_by_zero, 1'b0);

    for (int i = 0; i < 14; i++)
      check_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // Results hold while idle.
    repeat (5) step();
    check("hold.q", bus.quotient, 32'd333);
    check("hold.r", bus.remainder, 32'd1);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      model(rs, ra, rb, q, r, dz);
      check_op($sformatf("rnd%0d", i), rs, ra, rb, q, r, dz);
    end

    // Start during an operation is ignored; start in the done cycle is not
    // accepted, but held one more edge it is.
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.dividend = 32'd9;
    bus.divisor  = 32'd9;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 10;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    check("busy_start.lat", lat, 33);
    check("busy_start.q",   bus.quotient, 32'd333);
    check("busy_start.r",   bus.remainder, 32'd1);
    bus.start = 1'b1;
    step();
    check("done_start.busy", bus.busy, 1'b0);
    check("done_start.q",    bus.quotient, 32'd333);
    step();
    bus.start = 1'b0;
    check("late_start.busy", bus.busy, 1'b1);
    check("late_start.q",    bus.quotient, 32'd0);
    lat = 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    check("late_start.lat", lat, 33);
    check("late_start.q2",  bus.quotient, 32'd1);
    check("late_start.r2",  bus.remainder, 32'd0);
    step();

    // Reset mid-operation aborts without a done pulse.
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", bus.busy, 1'b0);
    check("abort.done", bus.done, 1'b0);
    check("abort.q",    bus.quotient, 32'd0);
    check("abort.r",    bus.remainder, 32'd0);
    seen_done = 0;
    seen_busy = 0;
    repeat (40) begin
      step();
      if (bus.done) seen_done++;
      if (bus.busy) seen_busy++;
    end
    check("abort.no_done", seen_done, 0);
    check("abort.no_busy", seen_busy, 0);

    // div_by_zero flag holds in idle and clears on the next accept edge.
    check_op("dz_pre", 1'b0, 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, 1'b1);
    step();
    check("dz_hold", bus.div_by_zero, 1'b1);
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check("dz_clear.dz", bus.div_by_zero, 1'b0);
    check("dz_clear.q",  bus.quotient, 32'd0);
    lat = 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    check("after_abort.lat", lat, 33);
    check("after_abort.q",   bus.quotient, 32'd10);
    check("after_abort.r",   bus.remainder, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
